// File: rtl/uart_host_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_host_ctrl_pkg
//  Description : Shared constants for the UART host controller: register
//                map of the UART core, STATUS bit positions, FSM encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_host_ctrl_pkg;

    // UART core register map
    localparam logic [1:0] C_ADDR_TX     = 2'd0;
    localparam logic [1:0] C_ADDR_RX     = 2'd1;
    localparam logic [1:0] C_ADDR_STATUS = 2'd2;

    // STATUS register bit positions
    localparam int C_STAT_RX_READY = 0;
    localparam int C_STAT_TX_BUSY  = 1;

    // Controller FSM encoding
    localparam logic [1:0] C_ST_POLL  = 2'd0;
    localparam logic [1:0] C_ST_RX_RD = 2'd1;
    localparam logic [1:0] C_ST_TX_WR = 2'd2;
    localparam logic [1:0] C_ST_ACK   = 2'd3;

    // Register address the bus presents while the FSM sits in a given state
    function automatic logic [1:0] state_bus_addr(input logic [1:0] state);
        logic [1:0] addr;
        case (state)
            C_ST_RX_RD: addr = C_ADDR_RX;
            C_ST_TX_WR: addr = C_ADDR_TX;
            default:    addr = C_ADDR_STATUS;
        endcase
        return addr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : Synchronous FIFO with show-ahead read and occupancy output.
//                Pointers carry one extra wrap bit so full and empty are
//                distinguished by the pointer difference alone.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_pop_data,
    output logic                     o_valid,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int C_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [C_AW:0]    r_wr_ptr;
    logic [C_AW:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_level    = r_wr_ptr - r_rd_ptr;
    assign o_full     = (o_level == (C_AW + 1)'(DEPTH));
    assign o_valid    = (o_level != '0);
    assign o_pop_data = r_mem[r_rd_ptr[C_AW-1:0]];
    assign w_do_push  = i_push && !o_full;
    assign w_do_pop   = i_pop && o_valid;

    // Storage array; contents need no reset since valid tracks occupancy
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[C_AW-1:0]] <= i_push_data;
        end
    end

    // Read/write pointers advance independently; push+pop keeps the level
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + (C_AW + 1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (C_AW + 1)'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_host_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_host_ctrl
//  Description : Sole bus master on the UART core register port. Polls
//                STATUS, writes bytes from the TX stream into the core and
//                drains received bytes into a local RX FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_host_ctrl #(
    parameter int RX_DEPTH    = 16,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [7:0]                  s_tx_data,
    input  logic                        s_tx_valid,
    output logic                        s_tx_ready,
    output logic [7:0]                  m_rx_data,
    output logic                        m_rx_valid,
    input  logic                        m_rx_ready,
    output logic                        bus_wr,
    output logic [1:0]                  bus_addr,
    output logic [7:0]                  bus_wdata,
    input  logic [7:0]                  bus_rdata,
    input  logic                        bus_ack,
    output logic [$clog2(RX_DEPTH):0]   rx_level,
    output logic                        err_timeout
);

    import uart_host_ctrl_pkg::*;

    localparam int                C_TO_W    = $clog2(ACK_TIMEOUT);
    localparam logic [C_TO_W-1:0] C_TO_LAST = C_TO_W'(ACK_TIMEOUT - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              w_timeout;
    logic [C_TO_W-1:0] r_to_cnt;
    logic              r_hold_valid;
    logic [7:0]        r_hold_data;
    logic              w_fifo_full;

    assign s_tx_ready = !r_hold_valid;

    // Next-state decode; RX wins over TX because the core cannot stall RX
    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        case (r_state)
            C_ST_POLL: begin
                if (bus_rdata[C_STAT_RX_READY] && !w_fifo_full) begin
                    w_state_nxt = C_ST_RX_RD;
                end else if (r_hold_valid && !bus_rdata[C_STAT_TX_BUSY]) begin
                    w_state_nxt = C_ST_TX_WR;
                end
            end
            C_ST_RX_RD, C_ST_TX_WR: begin
                w_state_nxt = C_ST_ACK;
            end
            C_ST_ACK: begin
                if (bus_ack) begin
                    w_state_nxt = C_ST_POLL;
                end else if (r_to_cnt == C_TO_LAST) begin
                    w_state_nxt = C_ST_POLL;
                    w_timeout   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = C_ST_POLL;
            end
        endcase
    end

    // State, registered bus controls, ack-wait counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= C_ST_POLL;
            bus_wr      <= 1'b0;
            bus_addr    <= C_ADDR_STATUS;
            r_to_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            bus_wr   <= (w_state_nxt == C_ST_RX_RD) || (w_state_nxt == C_ST_TX_WR);
            bus_addr <= state_bus_addr(w_state_nxt);
            // Counter is zero on ACK entry and advances once per ACK cycle
            r_to_cnt <= (r_state == C_ST_ACK) ? r_to_cnt + C_TO_W'(1) : '0;
            if (w_timeout) begin
                err_timeout <= 1'b1;
            end
        end
    end

    // TX holding register and write-data latch for the upcoming TX strobe
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_hold_valid <= 1'b0;
            r_hold_data  <= 8'h00;
            bus_wdata    <= 8'h00;
        end else begin
            if (s_tx_valid && s_tx_ready) begin
                r_hold_valid <= 1'b1;
                r_hold_data  <= s_tx_data;
            end else if (r_state == C_ST_TX_WR) begin
                r_hold_valid <= 1'b0;
            end
            if (w_state_nxt == C_ST_TX_WR) begin
                bus_wdata <= r_hold_data;
            end
        end
    end

    uart_rx_fifo #(
        .DEPTH (RX_DEPTH),
        .WIDTH (8)
    ) u_rx_fifo (
        .clk         (clk),
        .rstn        (rstn),
        .i_push      (r_state == C_ST_RX_RD),
        .i_push_data (bus_rdata),
        .i_pop       (m_rx_ready),
        .o_pop_data  (m_rx_data),
        .o_valid     (m_rx_valid),
        .o_full      (w_fifo_full),
        .o_level     (rx_level)
    );

endmodule
`default_nettype wire

// File: tb/tb_uart_host_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_uart_host_ctrl
//  Description : Self-checking bench for uart_host_ctrl with a behavioural
//                UART core responder and queue-based stream reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_host_ctrl;

    localparam int RX_DEPTH    = 16;
    localparam int ACK_TIMEOUT = 16;

    logic       clk        = 1'b0;
    logic       rstn       = 1'b0;
    logic [7:0] s_tx_data  = 8'h00;
    logic       s_tx_valid = 1'b0;
    logic       s_tx_ready;
    logic [7:0] m_rx_data;
    logic       m_rx_valid;
    logic       m_rx_ready = 1'b0;
    logic       bus_wr;
    logic [1:0] bus_addr;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata;
    logic       bus_ack;
    logic [4:0] rx_level;
    logic       err_timeout;

    uart_host_ctrl #(
        .RX_DEPTH    (RX_DEPTH),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .s_tx_data   (s_tx_data),
        .s_tx_valid  (s_tx_valid),
        .s_tx_ready  (s_tx_ready),
        .m_rx_data   (m_rx_data),
        .m_rx_valid  (m_rx_valid),
        .m_rx_ready  (m_rx_ready),
        .bus_wr      (bus_wr),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_rdata   (bus_rdata),
        .bus_ack     (bus_ack),
        .rx_level    (rx_level),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- UART core responder ----------------
    bit         ack_en    = 1'b1;
    bit         rand_mode = 1'b0;
    logic       core_rx_rdy;
    logic [7:0] core_rx_byte;
    int         busy_cnt;
    int         rx_sent_n = 0;
    logic [7:0] core_rx_q[$];
    logic [7:0] tx_seen_q[$];

    assign bus_rdata = (bus_addr == 2'd2) ? {6'd0, (busy_cnt != 0), core_rx_rdy} :
                       (bus_addr == 2'd1) ? core_rx_byte : 8'h00;

    // Core: ack one cycle after strobe, busy after a TX write, RX byte source
    always @(posedge clk) begin
        if (!rstn) begin
            core_rx_rdy  <= 1'b0;
            core_rx_byte <= 8'h00;
            busy_cnt     <= 0;
            bus_ack      <= 1'b0;
        end else begin
            bus_ack <= bus_wr && ack_en;
            if (bus_wr && bus_addr == 2'd0) begin
                tx_seen_q.push_back(bus_wdata);
                busy_cnt <= rand_mode ? int'($urandom_range(1, 5)) : 2;
            end else if (busy_cnt != 0) begin
                busy_cnt <= busy_cnt - 1;
            end
            if (bus_wr && bus_addr == 2'd1) begin
                rx_sent_n   <= rx_sent_n + 1;
                core_rx_rdy <= 1'b0;
            end else if (!core_rx_rdy && core_rx_q.size() != 0 &&
                         (!rand_mode || $urandom_range(0, 3) == 0)) begin
                core_rx_byte <= core_rx_q.pop_front();
                core_rx_rdy  <= 1'b1;
            end
        end
    end

    // ---------------- Stream and protocol monitors ----------------
    int         cyc         = 0;
    int         last_strobe = -10;
    int         rx_pop_n    = 0;
    int         tx_acc_n    = 0;
    logic [7:0] got_rx_q[$];
    logic [7:0] exp_rx_q[$];
    logic [7:0] exp_tx_q[$];

    // Record handshakes and check strobe spacing / legality at each edge
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rstn) begin
            if (bus_wr) begin
                chk("strobe_spacing", 32'((cyc - last_strobe) >= 3), 32'd1);
                if (bus_addr == 2'd1) chk("rx_strobe_legal", 32'(core_rx_rdy), 32'd1);
                last_strobe <= cyc;
            end
            if (m_rx_valid && m_rx_ready) begin
                got_rx_q.push_back(m_rx_data);
                rx_pop_n <= rx_pop_n + 1;
            end
            if (s_tx_valid && s_tx_ready) tx_acc_n <= tx_acc_n + 1;
        end
    end

    // ---------------- Directed vector table ----------------
    typedef struct {
        bit         is_tx;
        logic [7:0] data;
        logic [1:0] exp_addr;
        int         exp_lat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int s;
        int idx;
        int acc_mark;
        bit done;
        logic [7:0] txb[48];

        vecs[0] = '{1'b1, 8'hA5, 2'd0, 2};
        vecs[1] = '{1'b0, 8'h3C, 2'd1, 2};
        vecs[2] = '{1'b1, 8'h00, 2'd0, 2};
        vecs[3] = '{1'b0, 8'hFF, 2'd1, 2};
        vecs[4] = '{1'b1, 8'h5A, 2'd0, 2};
        vecs[5] = '{1'b0, 8'h81, 2'd1, 2};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_bus_wr", 32'(bus_wr), 32'd0);
        chk("rst_bus_addr", 32'(bus_addr), 32'd2);
        chk("rst_bus_wdata", 32'(bus_wdata), 32'h00);
        chk("rst_tx_ready", 32'(s_tx_ready), 32'd1);
        chk("rst_rx_valid", 32'(m_rx_valid), 32'd0);
        chk("rst_rx_level", 32'(rx_level), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        rstn = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("idle_bus_wr", 32'(bus_wr), 32'd0);
            chk("idle_bus_addr", 32'(bus_addr), 32'd2);
        end
        chk("idle_tx_ready", 32'(s_tx_ready), 32'd1);
        chk("idle_rx_level", 32'(rx_level), 32'd0);

        // Single transfers from the table
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].is_tx) begin
                s_tx_valid = 1'b1;
                s_tx_data  = vecs[i].data;
                exp_tx_q.push_back(vecs[i].data);
            end else begin
                core_rx_q.push_back(vecs[i].data);
                exp_rx_q.push_back(vecs[i].data);
            end
            @(negedge clk);
            n = 1;
            s_tx_valid = 1'b0;
            if (vecs[i].is_tx) chk("tx_ready_after_accept", 32'(s_tx_ready), 32'd0);
            while (!bus_wr && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("vec_strobe_latency", 32'(n), 32'(vecs[i].exp_lat));
            chk("vec_strobe_addr", 32'(bus_addr), 32'(vecs[i].exp_addr));
            if (vecs[i].is_tx) begin
                chk("vec_wdata", 32'(bus_wdata), 32'(vecs[i].data));
                chk("tx_ready_in_tx_wr", 32'(s_tx_ready), 32'd0);
            end
            @(negedge clk);
            chk("vec_strobe_one_cycle", 32'(bus_wr), 32'd0);
            if (vecs[i].is_tx) begin
                chk("tx_ready_restored", 32'(s_tx_ready), 32'd1);
            end else begin
                chk("vec_rx_valid", 32'(m_rx_valid), 32'd1);
                chk("vec_rx_data", 32'(m_rx_data), 32'(vecs[i].data));
                chk("vec_rx_level", 32'(rx_level), 32'd1);
                m_rx_ready = 1'b1;
                @(negedge clk);
                m_rx_ready = 1'b0;
                chk("vec_rx_level_pop", 32'(rx_level), 32'd0);
                chk("vec_rx_valid_pop", 32'(m_rx_valid), 32'd0);
            end
            repeat (8) @(negedge clk);
        end

        // RX and TX pending in the same POLL: RX first, TX one POLL later
        s_tx_valid = 1'b1;
        s_tx_data  = 8'h77;
        exp_tx_q.push_back(8'h77);
        core_rx_q.push_back(8'h99);
        exp_rx_q.push_back(8'h99);
        @(negedge clk);
        n = 1;
        s_tx_valid = 1'b0;
        while (!bus_wr && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("prio_first_addr", 32'(bus_addr), 32'd1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_wr && n < 20);
        chk("prio_second_addr", 32'(bus_addr), 32'd0);
        chk("prio_second_wdata", 32'(bus_wdata), 32'h77);
        chk("prio_gap", 32'(n), 32'd3);
        m_rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        m_rx_ready = 1'b0;
        repeat (8) @(negedge clk);

        // Fill the FIFO with the consumer stalled
        for (int i = 0; i < RX_DEPTH + 1; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            core_rx_q.push_back(b);
            exp_rx_q.push_back(b);
        end
        n = 0;
        while (rx_level != 5'd16 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("fill_level", 32'(rx_level), 32'd16);
        s = rx_sent_n;
        repeat (20) @(negedge clk);
        chk("full_no_read", 32'(rx_sent_n), 32'(s));
        chk("full_core_waiting", 32'(core_rx_rdy), 32'd1);
        chk("full_level_held", 32'(rx_level), 32'd16);
        m_rx_ready = 1'b1;
        @(negedge clk);
        m_rx_ready = 1'b0;
        chk("full_pop_level", 32'(rx_level), 32'd15);
        n = 0;
        while (rx_level != 5'd16 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("full_read_resumes", 32'(rx_level), 32'd16);
        chk("full_read_count", 32'(rx_sent_n), 32'(s + 1));
        m_rx_ready = 1'b1;
        n = 0;
        while (rx_level != 5'd0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        m_rx_ready = 1'b0;
        chk("full_drained", 32'(rx_level), 32'd0);
        repeat (4) @(negedge clk);

        // Ack timeout on a TX write
        ack_en     = 1'b0;
        s_tx_valid = 1'b1;
        s_tx_data  = 8'hC3;
        exp_tx_q.push_back(8'hC3);
        @(negedge clk);
        n = 1;
        s_tx_valid = 1'b0;
        while (!bus_wr && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("to_strobe_addr", 32'(bus_addr), 32'd0);
        repeat (ACK_TIMEOUT) @(negedge clk);
        chk("to_err_not_yet", 32'(err_timeout), 32'd0);
        @(negedge clk);
        chk("to_err_set", 32'(err_timeout), 32'd1);
        chk("to_bus_wr", 32'(bus_wr), 32'd0);
        ack_en = 1'b1;
        // Next TX at minimum latency proves the FSM is back in POLL
        s_tx_valid = 1'b1;
        s_tx_data  = 8'h3E;
        exp_tx_q.push_back(8'h3E);
        @(negedge clk);
        n = 1;
        s_tx_valid = 1'b0;
        while (!bus_wr && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("to_after_latency", 32'(n), 32'd2);
        chk("to_after_wdata", 32'(bus_wdata), 32'h3E);
        repeat (6) @(negedge clk);
        chk("to_err_sticky", 32'(err_timeout), 32'd1);

        // Randomised traffic in both directions
        rand_mode = 1'b1;
        for (int i = 0; i < 48; i++) begin
            logic [7:0] b;
            txb[i] = 8'($urandom);
            exp_tx_q.push_back(txb[i]);
            b = 8'($urandom);
            core_rx_q.push_back(b);
            exp_rx_q.push_back(b);
        end
        idx      = 0;
        acc_mark = tx_acc_n;
        done     = 1'b0;
        for (int c = 0; c < 4000 && !done; c++) begin
            @(negedge clk);
            chk("rand_rx_level", 32'(rx_level), 32'(rx_sent_n - rx_pop_n));
            if (s_tx_valid && tx_acc_n != acc_mark) begin
                s_tx_valid = 1'b0;
                acc_mark   = tx_acc_n;
                idx++;
            end
            if (!s_tx_valid && idx < 48 && $urandom_range(0, 2) == 0) begin
                s_tx_valid = 1'b1;
                s_tx_data  = txb[idx];
            end
            m_rx_ready = ($urandom_range(0, 1) == 1);
            done = (idx == 48) && !s_tx_valid && (core_rx_q.size() == 0) && !core_rx_rdy &&
                   (rx_level == 5'd0) && (tx_seen_q.size() == exp_tx_q.size());
        end
        chk("rand_completed", 32'(done), 32'd1);
        s_tx_valid = 1'b0;
        m_rx_ready = 1'b0;
        repeat (10) @(negedge clk);

        // End-to-end stream order against the reference queues
        chk("tx_stream_count", 32'(tx_seen_q.size()), 32'(exp_tx_q.size()));
        for (int i = 0; i < exp_tx_q.size() && i < tx_seen_q.size(); i++)
            chk("tx_stream_byte", 32'(tx_seen_q[i]), 32'(exp_tx_q[i]));
        chk("rx_stream_count", 32'(got_rx_q.size()), 32'(exp_rx_q.size()));
        for (int i = 0; i < exp_rx_q.size() && i < got_rx_q.size(); i++)
            chk("rx_stream_byte", 32'(got_rx_q[i]), 32'(exp_rx_q[i]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_host_ctrl.md
# uart_host_ctrl

Bus-master controller that drives the memory-mapped register port of the UART core on behalf of the USB-side datapath. Polls the core's STATUS register, moves bytes from a valid/ready TX stream into the TX register, drains received bytes into a local RX FIFO and presents them as a valid/ready stream. Sits between the USB endpoint logic and the UART core; it is the only master on the core's register port.

## Interface
- `RX_DEPTH`, 16: RX FIFO depth in bytes; power of two, ≥ 2.
- `ACK_TIMEOUT`, 16: maximum cycles spent waiting for `bus_ack` after a strobe; ≥ 2.

- `clk`  in  1  clock; all logic on the rising edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `s_tx_data`  in  8  byte to transmit.
- `s_tx_valid`  in  1  `s_tx_data` valid.
- `s_tx_ready`  out  1  TX holding register empty.
- `m_rx_data`  out  8  head of RX FIFO.
- `m_rx_valid`  out  1  RX FIFO non-empty.
- `m_rx_ready`  in  1  consumer pops the head.
- `bus_wr`  out  1  register strobe: TX write at addr 0, RX-ready clear at addr 1.
- `bus_addr`  out  2  0 = TX, 1 = RX, 2 = STATUS.
- `bus_wdata`  out  8  TX byte.
- `bus_rdata`  in  8  combinational read data for `bus_addr`; at STATUS, bit0 = rx_ready, bit1 = tx_busy.
- `bus_ack`  in  1  asserted one cycle after `bus_wr`.
- `rx_level`  out  $clog2(RX_DEPTH)+1  RX FIFO occupancy.
- `err_timeout`  out  1  sticky; set on an ack timeout, cleared only by reset.

## Operation
- TX holding register: single byte plus valid flag. `s_tx_ready` = !hold_valid. The hold register loads on `s_tx_valid && s_tx_ready` and clears at the end of the TX_WR cycle.
- RX FIFO: RX_DEPTH entries with wrapping pointers of width log2(RX_DEPTH)+1. Show-ahead: `m_rx_data` = mem[rd_ptr]. Pop on `m_rx_valid && m_rx_ready`. A simultaneous push and pop leaves `rx_level` unchanged. The FIFO never overflows, because no read is issued while it is full.
- FSM states: POLL, RX_RD, TX_WR, ACK.
  - POLL: `bus_addr`=2, `bus_wr`=0. Sample `bus_rdata`.
    - If bit0=1 and the FIFO is not full → RX_RD.
    - Else if hold_valid and bit1=0 → TX_WR.
    - Else stay in POLL.
    - RX has priority because the core has no RX flow control.
  - RX_RD: `bus_addr`=1, `bus_wr`=1. Push `bus_rdata` into the FIFO on this edge. Next state → ACK.
  - TX_WR: `bus_addr`=0, `bus_wr`=1, `bus_wdata`=hold byte. Clear hold_valid. Next state → ACK.
  - ACK: `bus_addr`=2, `bus_wr`=0. Leave on `bus_ack` → POLL.
    - Timeout counter is zeroed on entry and increments each ACK cycle.
    - At `ACK_TIMEOUT`-1 without ack: set `err_timeout` and go to POLL.
    - The transferred byte is not retried.
- RX FIFO full while rx_ready=1: stay in POLL without reading. The byte waits in the core. If the core overwrites it, that loss is accepted.
- Reset mid-operation: the FSM returns to POLL and the FIFO and hold register empty. An in-flight byte is discarded.

## Timing
- Reset values:
  - `bus_wr`=0, `bus_addr`=2, `bus_wdata`=0x00
  - `s_tx_ready`=1, `m_rx_valid`=0, `m_rx_data` undefined, `rx_level`=0
  - `err_timeout`=0, state POLL
- `bus_wr` and `bus_addr` are registered, driven from the state. `bus_wr` is high for exactly one cycle per transfer.
- One transfer takes 3 cycles: POLL, RX_RD/TX_WR, ACK with ack. The minimum spacing between strobes is 3 cycles.
- Byte to UART: earliest TX_WR is 2 cycles after the accept edge of the `s_tx` handshake, provided STATUS shows tx_busy=0.
- Byte from UART: RX_RD follows the POLL cycle that sees rx_ready=1. `m_rx_valid` rises the cycle after RX_RD.
- In ACK the core has already cleared rx_ready or set tx_busy, so the next POLL sample is current.

## Structure
- Shared package: register address constants (TX=0, RX=1, STATUS=2), status bit indices (RX_READY=0, TX_BUSY=1), FSM state encoding.
- One sub-module: `uart_rx_fifo` (parameterised sync FIFO with show-ahead read and a level output). FSM and hold register live in the top.

## Test plan
- After reset, idle core with STATUS=0x00 → `bus_addr`=2, `bus_wr`=0 steady, `s_tx_ready`=1, `rx_level`=0.
- Push 0xA5 via `s_tx`, core tx_busy=0 → one strobe with addr 0, wdata 0xA5. `s_tx_ready` drops for the duration and returns to 1 after TX_WR.
- Core presents rx_ready=1 with RX data 0x3C → strobe at addr 1. Then `m_rx_valid`=1, `m_rx_data`=0x3C, `rx_level`=1. Pop returns `rx_level` to 0.
- rx_ready and a pending TX byte in the same POLL → RX_RD is issued first, TX_WR follows after the next POLL.
- Fill the FIFO with 16 bytes while `m_rx_ready`=0, rx_ready held at 1 → no further strobes at addr 1. Pop one byte → read resumes and `rx_level` returns to 16.
- Hold `bus_ack`=0 after a TX strobe → after `ACK_TIMEOUT` cycles `err_timeout`=1 and the FSM is in POLL. Subsequent transfers work normally.
